// File: rtl/microwave_timer.sv
// MM:SS BCD countdown timer for the magnetron control stage with keypad shift-in entry.
// Define MICROWAVE_TIMER_PRESCALE_EN for one decrement per CLK_HZ cycles; otherwise every cooking cycle is a tick.
module microwave_timer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int PRE_W  = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       magnetron_on,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       zero,
  output logic       timer_done
);

  logic       tick;
  logic       accept;
  logic [3:0] mt_dec, mu_dec, st_dec, su_dec;

  assign zero   = ~|{min_tens, min_units, sec_tens, sec_units};
  assign accept = digit_valid && !magnetron_on && (digit <= 4'd9);

`ifdef MICROWAVE_TIMER_PRESCALE_EN
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  logic [PRE_W-1:0] pre;

  assign tick = magnetron_on && !zero && (pre == PRE_MAX);

  // A paused partial second is discarded: the prescaler restarts whenever cooking stops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                      pre <= '0;
    else if (!clearn || !magnetron_on || zero || tick) pre <= '0;
    else                                              pre <= pre + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLK_HZ, PRE_W};
  assign tick       = magnetron_on && !zero;
`endif

  // Borrow chain; sec_tens above 5 (shifted-in 6..9) simply decrements.
  always_comb begin
    su_dec = sec_units - 4'd1;
    st_dec = sec_tens;
    mu_dec = min_units;
    mt_dec = min_tens;
    if (sec_units == 4'd0) begin
      su_dec = 4'd9;
      if (sec_tens == 4'd0) begin
        st_dec = 4'd5;
        if (min_units == 4'd0) begin
          mu_dec = 4'd9;
          mt_dec = min_tens - 4'd1;
        end else begin
          mu_dec = min_units - 4'd1;
        end
      end else begin
        st_dec = sec_tens - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens  <= '0;
      min_units <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
    end else if (!clearn) begin
      min_tens  <= '0;
      min_units <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
    end else if (tick) begin
      min_tens  <= mt_dec;
      min_units <= mu_dec;
      sec_tens  <= st_dec;
      sec_units <= su_dec;
    end else if (accept) begin
      min_tens  <= min_units;
      min_units <= sec_tens;
      sec_tens  <= sec_units;
      sec_units <= digit;
    end
  end

  // Done is sampled on the time before the edge, so it lands one edge after the last decrement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   timer_done <= 1'b0;
    else if (!clearn)              timer_done <= 1'b0;
    else if (magnetron_on && zero) timer_done <= 1'b1;
    else if (accept)               timer_done <= 1'b0;
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: table of entry/clear vectors plus countdown sequences.
module tb_microwave_timer;
`ifdef MICROWAVE_TIMER_PRESCALE_EN
  localparam int TICK = 4;
`else
  localparam int TICK = 1;
`endif

  logic clk = 1'b0, resetn = 1'b0, clearn = 1'b1, magnetron_on = 1'b0, digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic zero, timer_done;
  int nchk = 0, nerr = 0;

  microwave_timer #(.CLK_HZ(4), .PRE_W(3)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .magnetron_on(magnetron_on),
    .digit_valid(digit_valid), .digit(digit),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .zero(zero), .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr_n, mag, dv;
    logic [3:0]  d;
    logic [15:0] t;
    logic        z, dn;
    string       nm;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [15:0] et, input logic ez, input logic ed);
    nchk++;
    if ({min_tens, min_units, sec_tens, sec_units} !== et || zero !== ez || timer_done !== ed) begin
      nerr++;
      $display("FAIL %s: got %h zero=%b done=%b, want %h zero=%b done=%b", nm,
               {min_tens, min_units, sec_tens, sec_units}, zero, timer_done, et, ez, ed);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; digit = d;
    cyc();
    digit_valid = 1'b0;
  endtask

  task automatic clear();
    clearn = 1'b0; cyc(); clearn = 1'b1;
  endtask

  initial begin
    logic [15:0] e;
    int v;
    tv[0]  = '{1'b1, 1'b0, 1'b1, 4'd1,  16'h0001, 1'b0, 1'b0, "key1"};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 4'd3,  16'h0013, 1'b0, 1'b0, "key3"};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 4'd0,  16'h0130, 1'b0, 1'b0, "key0"};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 4'd12, 16'h0130, 1'b0, 1'b0, "key12_ignored"};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 4'd5,  16'h0130, 1'b0, 1'b0, "no_strobe"};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 4'd7,  16'h0000, 1'b1, 1'b0, "clear_beats_digit"};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, "start_at_zero_done"};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 4'd4,  16'h0000, 1'b1, 1'b1, "strobe_while_cooking"};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, "done_holds_mag_off"};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 4'd15, 16'h0000, 1'b1, 1'b1, "bad_digit_keeps_done"};
    tv[10] = '{1'b1, 1'b0, 1'b1, 4'd9,  16'h0009, 1'b0, 1'b0, "digit_clears_done"};
    tv[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, "clear"};

    #12 chk("reset_state", 16'h0000, 1'b1, 1'b0);
    @(negedge clk); resetn = 1'b1;
    cyc();
    chk("idle_after_reset", 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      clearn = tv[i].clr_n; magnetron_on = tv[i].mag; digit_valid = tv[i].dv; digit = tv[i].d;
      cyc();
      chk(tv[i].nm, tv[i].t, tv[i].z, tv[i].dn);
    end
    clearn = 1'b1; magnetron_on = 1'b0; digit_valid = 1'b0;

    // Async reset in the middle of a count.
    key(1); key(2); key(3);
    chk("loaded_0123", 16'h0123, 1'b0, 1'b0);
    magnetron_on = 1'b1;
    @(posedge clk); #2 resetn = 1'b0;
    #1 chk("async_reset_midcount", 16'h0000, 1'b1, 1'b0);
    magnetron_on = 1'b0;
    @(negedge clk); resetn = 1'b1;

    // Minute borrow: 10:00 -> 09:59.
    key(1); key(0); key(0); key(0);
    magnetron_on = 1'b1;
    for (int k = 0; k < TICK; k++) cyc();
    chk("borrow_1000", 16'h0959, 1'b0, 1'b0);
    magnetron_on = 1'b0; clear();

    // 00:90 counts down through 89..80, 79.. and reaches 00:00 after 90 ticks.
    key(9); key(0);
    magnetron_on = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      for (int c = 0; c < TICK; c++) cyc();
      v = 90 - k;
      e = {8'h00, 4'(v / 10), 4'(v % 10)};
      chk($sformatf("cnt90_k%0d", k), e, (v == 0), 1'b0);
    end
    cyc();
    chk("done_after_final", 16'h0000, 1'b1, 1'b1);
    cyc();
    chk("stays_zero", 16'h0000, 1'b1, 1'b1);
    magnetron_on = 1'b0; clear();

    // Clear coinciding with a tick at 00:05, then start at 00:00.
    key(5);
    magnetron_on = 1'b1;
    for (int k = 0; k < TICK - 1; k++) cyc();
    chk("pre_tick_0005", 16'h0005, 1'b0, 1'b0);
    clearn = 1'b0; cyc(); clearn = 1'b1;
    chk("clear_beats_tick", 16'h0000, 1'b1, 1'b0);
    cyc();
    chk("start_zero_done", 16'h0000, 1'b1, 1'b1);
    magnetron_on = 1'b0; clear();

`ifdef MICROWAVE_TIMER_PRESCALE_EN
    // 01:00 with CLK_HZ=4, pause after 10 cycles, then resume.
    key(1); key(0); key(0);
    magnetron_on = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      e = (c < 4) ? 16'h0100 : (c < 8) ? 16'h0059 : 16'h0058;
      chk($sformatf("pre_c%0d", c), e, 1'b0, 1'b0);
    end
    magnetron_on = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    chk("paused", 16'h0058, 1'b0, 1'b0);
    magnetron_on = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("resume_c%0d", c), (c < 4) ? 16'h0058 : 16'h0057, 1'b0, 1'b0);
    end
`else
    // 00:02 counts down one step per cooking cycle.
    key(0); key(2);
    magnetron_on = 1'b1;
    cyc(); chk("fast_0001", 16'h0001, 1'b0, 1'b0);
    cyc(); chk("fast_0000", 16'h0000, 1'b1, 1'b0);
    cyc(); chk("fast_done", 16'h0000, 1'b1, 1'b1);
    cyc(); chk("fast_hold", 16'h0000, 1'b1, 1'b1);
`endif
    magnetron_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
